pc_sequencer: RTL and testbench

Fetch-side controller that owns the Program Counter register and sequences the next-PC selection between sequential (PC + 4), jump, branch and exception-vector addresses. It drives a single-outstanding request/response handshake to instruction memory, hands fetched words to decode with stall back-pressure, and squashes wrong-path fetches after any redirect. It sits between the control unit and branch/exception logic on one side and instruction memory and decode on the other.

---
 rtl/pc_sequencer_if.sv | 25 ++
 rtl/pc_sequencer.sv | 141 ++++++++++++++
 tb/tb_pc_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch bus: one outstanding request, response arrives later.
// The sequencer drives the request side; memory drives ready/valid/rdata.
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_valid,
        output imem_rdata
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-side PC owner: picks the next PC, runs the single-outstanding imem
// handshake, hands words to decode and squashes wrong-path responses.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  jump,
    input  logic [31:0]           jump_address,
    input  logic                  branch_taken,
    input  logic [31:0]           branch_target,
    input  logic                  exception,
    input  logic [31:0]           exc_pc,
    pc_sequencer_if.master        mem,
    output logic                  instr_valid,
    output logic [31:0]           instr,
    output logic [31:0]           instr_pc,
    output logic [31:0]           pc,
    output logic [31:0]           epc,
    output logic                  flush,
    output logic                  misaligned
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        redirect;
    logic [31:0] target;
    logic        req;
    logic        handshake;
    logic        capture;

    // Redirect priority: exception over taken branch over jump.
    always_comb begin
        redirect = exception | branch_taken | jump;
        target   = jump_address;
        if (exception) begin
            target = EXC_VECTOR;
        end else if (branch_taken) begin
            target = branch_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A response is only trusted in WAIT; a redirect turns any accepted
    // address into wrong-path, which DRAIN then swallows.
    always_comb begin
        next_state = state;
        req        = 1'b0;
        handshake  = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                next_state = ST_REQ;
            end
            ST_REQ: begin
                req       = !(instr_valid && stall);
                handshake = req && mem.imem_ready;
                if (handshake) begin
                    next_state = redirect ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem.imem_valid) begin
                    capture    = !redirect;
                    next_state = ST_REQ;
                end else if (redirect) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mem.imem_valid) begin
                    next_state = ST_REQ;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign mem.imem_req  = req;
    assign mem.imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            epc        <= 32'h0;
            flush      <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            flush      <= redirect;
            misaligned <= redirect && (target[1:0] != 2'b00);
            if (redirect) begin
                pc <= target & ~32'h3;
            end else if (capture) begin
                pc <= pc + 32'd4;
            end
            if (exception) begin
                epc <= exc_pc;
            end
        end
    end

    // The decode slot is held under stall but a redirect always empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
        end else begin
            if (redirect) begin
                instr_valid <= 1'b0;
            end else if (capture) begin
                instr_valid <= 1'b1;
            end else if (!stall) begin
                instr_valid <= 1'b0;
            end
            if (capture) begin
                instr    <= mem.imem_rdata;
                instr_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random traffic,
// compared every cycle against a transaction-level model of the fetch unit.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_address = 32'h0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        exception = 1'b0;
    logic [31:0] exc_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        flush;
    logic        misaligned;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC   (RESET_PC),
        .EXC_VECTOR (EXC_VECTOR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .jump          (jump),
        .jump_address  (jump_address),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .exception     (exception),
        .exc_pc        (exc_pc),
        .mem           (bus),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .pc            (pc),
        .epc           (epc),
        .flush         (flush),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: what the fetch unit has promised, not how it is built.
    logic [31:0] m_pc, m_epc, m_instr, m_instr_pc;
    logic        m_iv, m_flush, m_mis;
    logic        m_started;
    logic        m_pending;
    logic        m_squash;

    // Behavioural memory: remembers the one accepted address.
    logic        mem_pending = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic        hs_seen;
    logic        valid_seen;
    logic [31:0] addr_seen;
    logic        last_hs = 1'b0;
    logic [31:0] hs_log[$];
    logic [31:0] saved_instr;
    logic [31:0] saved_instr_pc;
    logic        found;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_pc       = RESET_PC;
        m_epc      = 32'h0;
        m_instr    = 32'h0;
        m_instr_pc = 32'h0;
        m_iv       = 1'b0;
        m_flush    = 1'b0;
        m_mis      = 1'b0;
        m_started  = 1'b0;
        m_pending  = 1'b0;
        m_squash   = 1'b0;
    endtask

    function automatic logic model_req();
        return m_started && !m_pending && !(m_iv && stall);
    endfunction

    task automatic modelStep();
        logic        redir;
        logic [31:0] tgt;
        logic        hs;
        logic        cap;
        redir = exception | branch_taken | jump;
        tgt   = exception ? EXC_VECTOR : (branch_taken ? branch_target : jump_address);
        hs    = model_req() && bus.imem_ready;
        cap   = m_pending && !m_squash && bus.imem_valid && !redir;
        m_flush = redir;
        m_mis   = redir && (tgt[1:0] != 2'b00);
        if (exception) m_epc = exc_pc;
        if (cap) begin
            m_instr    = bus.imem_rdata;
            m_instr_pc = m_pc;
        end
        if (redir) m_pc = {tgt[31:2], 2'b00};
        else if (cap) m_pc = m_pc + 32'd4;
        if (redir) m_iv = 1'b0;
        else if (cap) m_iv = 1'b1;
        else if (!stall) m_iv = 1'b0;
        if (hs) begin
            m_pending = 1'b1;
            m_squash  = redir;
        end else if (m_pending && bus.imem_valid) begin
            m_pending = 1'b0;
            m_squash  = 1'b0;
        end else if (m_pending && redir) begin
            m_squash = 1'b1;
        end
        m_started = 1'b1;
    endtask

    // vmode: 0 no response, 1 respond when pending, 2 random when pending, 3 forced
    task automatic applyStimulus(input logic st, input logic jp, input logic [31:0] ja,
                                 input logic br, input logic [31:0] bt,
                                 input logic ex, input logic [31:0] ep,
                                 input logic rdy, input int vmode);
        logic v;
        stall         = st;
        jump          = jp;
        jump_address  = ja;
        branch_taken  = br;
        branch_target = bt;
        exception     = ex;
        exc_pc        = ep;
        case (vmode)
            0:       v = 1'b0;
            1:       v = mem_pending;
            2:       v = mem_pending && ($urandom_range(0, 2) != 0);
            default: v = 1'b1;
        endcase
        bus.imem_ready = rdy;
        bus.imem_valid = v;
        bus.imem_rdata = v ? mem_word(mem_addr) : $urandom();
    endtask

    task automatic checkOutput();
        check("pc", pc, m_pc);
        check("imem_addr", bus.imem_addr, m_pc);
        check("imem_req", {31'h0, bus.imem_req}, {31'h0, model_req()});
        check("instr_valid", {31'h0, instr_valid}, {31'h0, m_iv});
        check("instr", instr, m_instr);
        check("instr_pc", instr_pc, m_instr_pc);
        check("epc", epc, m_epc);
        check("flush", {31'h0, flush}, {31'h0, m_flush});
        check("misaligned", {31'h0, misaligned}, {31'h0, m_mis});
    endtask

    task automatic cycle(input logic st, input logic jp, input logic [31:0] ja,
                         input logic br, input logic [31:0] bt,
                         input logic ex, input logic [31:0] ep,
                         input logic rdy, input int vmode);
        applyStimulus(st, jp, ja, br, bt, ex, ep, rdy, vmode);
        #1;
        checkOutput();
        hs_seen    = bus.imem_req && bus.imem_ready && rst_n;
        valid_seen = bus.imem_valid;
        addr_seen  = bus.imem_addr;
        @(posedge clk);
        if (!rst_n) begin
            modelReset();
            mem_pending = 1'b0;
        end else begin
            modelStep();
            if (valid_seen) mem_pending = 1'b0;
            if (hs_seen) begin
                mem_pending = 1'b1;
                mem_addr    = addr_seen;
                hs_log.push_back(addr_seen);
            end
        end
        last_hs = hs_seen;
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy, input int vmode);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, rdy, vmode);
    endtask

    task automatic checkResetValues();
        check("rst_pc", pc, RESET_PC);
        check("rst_imem_req", {31'h0, bus.imem_req}, 32'h0);
        check("rst_imem_addr", bus.imem_addr, RESET_PC);
        check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_flush", {31'h0, flush}, 32'h0);
        check("rst_misaligned", {31'h0, misaligned}, 32'h0);
    endtask

    initial begin
        bus.imem_ready = 1'b0;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'h0;
        modelReset();

        // Reset and free-run with zero-wait memory
        repeat (2) @(negedge clk);
        checkResetValues();
        rst_n = 1'b1;
        hs_log.delete();
        repeat (10) idle(1'b1, 1);
        if (hs_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("seq_addr", hs_log[i], 32'(i * 4));
        end else begin
            check("seq_addr_count", 32'(hs_log.size()), 32'd4);
        end

        // Jump while a fetch is outstanding
        for (int i = 0; i < 10 && !last_hs; i++) idle(1'b1, 1);
        cycle(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 0);
        check("jump_flush", {31'h0, flush}, 32'h1);
        idle(1'b1, 1);
        check("jump_drop_valid", {31'h0, instr_valid}, 32'h0);
        hs_log.delete();
        repeat (4) idle(1'b1, 1);
        if (hs_log.size() > 0) check("jump_addr", hs_log[0], 32'h100);
        else check("jump_addr_count", 32'(hs_log.size()), 32'd1);

        // All redirects at once: exception wins
        cycle(1'b0, 1'b1, 32'h500, 1'b1, 32'h300, 1'b1, 32'h44, 1'b1, 1);
        check("exc_pc", pc, 32'h80);
        check("exc_epc", epc, 32'h44);

        // Stall with a live instruction
        for (int i = 0; i < 10 && !m_iv; i++) idle(1'b1, 1);
        saved_instr    = instr;
        saved_instr_pc = instr_pc;
        repeat (5) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1);
            check("stall_instr", instr, saved_instr);
            check("stall_instr_pc", instr_pc, saved_instr_pc);
            check("stall_no_req", {31'h0, bus.imem_req}, 32'h0);
        end
        repeat (4) idle(1'b1, 1);

        // Misaligned branch target
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0206, 1'b0, 32'h0, 1'b1, 1);
        check("mis_pc", pc, 32'h204);
        check("mis_pulse", {31'h0, misaligned}, 32'h1);
        idle(1'b1, 1);
        check("mis_clear", {31'h0, misaligned}, 32'h0);

        // Wrap from the top of the address space
        repeat (4) idle(1'b1, 1);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            idle(1'b1, 1);
            if (m_iv && m_instr_pc == 32'hFFFF_FFFC) found = 1'b1;
        end
        check("wrap_seen", {31'h0, found}, 32'h1);
        check("wrap_pc", pc, 32'h0);

        // Reset pulse while a fetch is outstanding; the late response is ignored
        for (int i = 0; i < 10 && !last_hs; i++) idle(1'b1, 1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        mem_pending = 1'b0;
        checkResetValues();
        @(negedge clk);
        idle(1'b0, 3);
        rst_n = 1'b1;
        idle(1'b0, 3);
        idle(1'b0, 3);
        check("late_valid_ignored", {31'h0, instr_valid}, 32'h0);
        hs_log.delete();
        repeat (4) idle(1'b1, 1);
        if (hs_log.size() > 0) check("restart_addr", hs_log[0], RESET_PC);
        else check("restart_addr_count", 32'(hs_log.size()), 32'd1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ja, bt;
            ja = $urandom();
            bt = $urandom();
            cycle($urandom_range(0, 3) == 0,
                  $urandom_range(0, 99) < 5, ja,
                  $urandom_range(0, 99) < 5, bt,
                  $urandom_range(0, 99) < 3, $urandom(),
                  $urandom_range(0, 1) == 1, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
